// File: rtl/read_module.sv
// Read-side consumer of the async FIFO: pops words two cycles apart, checks odd parity and a
// bounded, strictly increasing sequence, and keeps saturating statistics plus a sticky error flag.
module read_module #(
    parameter int DSIZE   = 16,
    parameter int CW      = 16,
    parameter int MAX_GAP = 3
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rd_en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             word_valid,
    output logic [DSIZE-1:0] word_out,
    output logic             parity_err,
    output logic             seq_err,
    output logic [CW-1:0]    word_count,
    output logic [CW-1:0]    parity_err_count,
    output logic [CW-1:0]    seq_err_count,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    localparam logic [DSIZE-1:0] GAP_MAX = DSIZE'(MAX_GAP);

    // Odd-parity contract: a word is in error when the XOR of all its bits is zero.
    function automatic logic parity_bad(input logic [DSIZE-1:0] w);
        return ~^w;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        logic [CW-1:0] res;
        if (en && (v != {CW{1'b1}})) begin
            res = v + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic             r_rinc;
    logic             r_word_valid;
    logic [DSIZE-1:0] r_word_out;
    logic             r_parity_err;
    logic             r_seq_err;
    logic [CW-1:0]    r_word_count;
    logic [CW-1:0]    r_parity_err_count;
    logic [CW-1:0]    r_seq_err_count;
    logic             r_err_sticky;
    logic [DSIZE-1:0] r_prev;
    logic             r_first;

    logic             w_capture;
    logic [DSIZE-1:0] w_delta;
    logic             w_par_err;
    logic             w_seq_err;

    // Next-state logic: a pop is only started after rempty=0 has been sampled.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET: w_next_state = S_IDLE;
            S_IDLE: begin
                if (rd_en && !rempty) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ:  w_next_state = S_CHECK;
            S_CHECK: begin
                if (rd_en && !rempty) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Word checks are evaluated on the head word at the edge that leaves READ.
    always_comb begin
        w_capture = (r_state == S_READ);
        w_delta   = rdata - r_prev;
        w_par_err = parity_bad(rdata);
        w_seq_err = !r_first && ((w_delta == {DSIZE{1'b0}}) || (w_delta > GAP_MAX));
    end

    // State, registered outputs, resync word and statistics.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state            <= S_RESET;
            r_rinc             <= 1'b0;
            r_word_valid       <= 1'b0;
            r_word_out         <= {DSIZE{1'b0}};
            r_parity_err       <= 1'b0;
            r_seq_err          <= 1'b0;
            r_word_count       <= {CW{1'b0}};
            r_parity_err_count <= {CW{1'b0}};
            r_seq_err_count    <= {CW{1'b0}};
            r_err_sticky       <= 1'b0;
            r_prev             <= {DSIZE{1'b0}};
            r_first            <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_rinc       <= (w_next_state == S_READ);
            r_word_valid <= w_capture;
            if (w_capture) begin
                // Checker resyncs to every popped word, even an erroneous one.
                r_word_out         <= rdata;
                r_parity_err       <= w_par_err;
                r_seq_err          <= w_seq_err;
                r_prev             <= rdata;
                r_first            <= 1'b0;
                r_word_count       <= sat_inc(r_word_count, 1'b1);
                r_parity_err_count <= sat_inc(r_parity_err_count, w_par_err);
                r_seq_err_count    <= sat_inc(r_seq_err_count, w_seq_err);
                r_err_sticky       <= r_err_sticky | w_par_err | w_seq_err;
            end else begin
                r_parity_err <= 1'b0;
                r_seq_err    <= 1'b0;
            end
        end
    end

    assign rinc             = r_rinc;
    assign word_valid       = r_word_valid;
    assign word_out         = r_word_out;
    assign parity_err       = r_parity_err;
    assign seq_err          = r_seq_err;
    assign word_count       = r_word_count;
    assign parity_err_count = r_parity_err_count;
    assign seq_err_count    = r_seq_err_count;
    assign err_sticky       = r_err_sticky;

endmodule
